vram_wr_arbiter: RTL and testbench
==================================

VRAM_WR_ARBITER -- requirements
Module: vram_wr_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: CPU write FIFO entries; power of two, at least 2; used only when VRAM_WR_ARB_FIFO_EN is defined.
REQ-002 SHALL have clk  input  1  clock; all logic on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have cpu_wraddr  input  12  HPS write word address.
REQ-005 SHALL have cpu_wrdata  input  128  HPS write data.
REQ-006 SHALL have cpu_wren  input  1  HPS write request; held with address and data while cpu_waitrequest=1.
REQ-007 SHALL have cpu_waitrequest  output  1  HPS write stalled this cycle.
REQ-008 SHALL have dma_wraddr  input  12  DMA engine write word address.
REQ-009 SHALL have dma_wrdata  input  128  DMA engine write data.
REQ-010 SHALL have dma_wren  input  1  DMA write request; held with address and data while dma_waitrequest=1.
REQ-011 SHALL have dma_waitrequest  output  1  DMA write stalled this cycle.
REQ-012 SHALL have sync_active  input  1  PPU in sync state; CPU-facing VRAM write port is locked.
REQ-013 SHALL have vram_wraddr  output  12  CPU-facing VRAM write address.
REQ-014 SHALL have vram_wrdata  output  128  CPU-facing VRAM write data.
REQ-015 SHALL have vram_wren  output  1  CPU-facing VRAM write strobe.
REQ-016 SHALL have idle  output  1  no write queued, held or issuing.

Function
REQ-017 SHALL accept a write on any port in a cycle where wren=1 and waitrequest=0; at most one grant per cycle.
REQ-018 SHALL have two candidates: CPU (cpu_wren, or a non-empty FIFO when enabled) and DMA (dma_wren).
REQ-019 SHALL grant the sole candidate; with both present, SHALL grant the source not in last_grant, then set last_grant to the granted source.
REQ-020 SHALL make no grant while sync_active=1 or while a write is held (REQ-022).
REQ-021 SHALL register a granted write: vram_wren=1 with its address and data exactly one cycle after the grant (latency 1).
REQ-022 SHALL hold a registered write issuing in a cycle with sync_active=1: vram_wren=0, address and data stable; SHALL issue it in the first cycle with sync_active=0.
REQ-023 SHALL drive vram_wren high for exactly one cycle per accepted write; vram_wraddr and vram_wrdata SHALL keep their last values otherwise.
REQ-024 SHALL drive dma_waitrequest combinationally: high when dma_wren=1 and the DMA is not granted that cycle.
REQ-025 SHALL preserve per-source write order; writes from different sources have no ordering guarantee.
REQ-026 SHALL drive idle=1 only when the FIFO is empty, no write is held and vram_wren=0.

Reset
REQ-027 SHALL, on rst_n=0, drive vram_wren=0, vram_wraddr=0, vram_wrdata=0 and idle=1, set last_grant=DMA and set the FIFO empty.
REQ-028 SHALL, on reset during operation, discard queued and held writes without issuing them; the first write after reset issues no earlier than 1 cycle after rst_n rises.

Configuration
REQ-029 SHALL, with VRAM_WR_ARB_FIFO_EN defined, buffer CPU writes in a FIFO_DEPTH FIFO: enqueue whenever not full, including during sync_active; cpu_waitrequest=full; full blocks enqueue even in a dequeue cycle; the FIFO head competes as the CPU candidate.
REQ-030 SHALL, without VRAM_WR_ARB_FIFO_EN, have no FIFO: cpu_waitrequest is high when cpu_wren=1 and the CPU is not granted that cycle, the same rule as the DMA port.

Structure
REQ-031 SHALL take VRAM_ADDR_W=12, VRAM_DATA_W=128, vram_wr_t (address and data) and arb_src_t (SRC_CPU, SRC_DMA) from shared package vram_pkg.
REQ-032 SHALL implement the FIFO as sub-module vram_wr_fifo, instantiated only under VRAM_WR_ARB_FIFO_EN.

Verification
REQ-033 SHALL cover: lone DMA write addr 0x010, data 0xA5.. -> dma_waitrequest=0; vram_wren one cycle later with addr 0x010.
REQ-034 SHALL cover: CPU (0x001) and DMA (0x002) both requesting continuously from reset -> VRAM order 0x001, 0x002, 0x001, 0x002.
REQ-035 SHALL cover: DMA granted in the cycle before sync_active rises and sync held 10 cycles -> vram_wren=0 for 10 cycles, then the held write issues with addr and data unchanged.
REQ-036 SHALL cover (FIFO on, depth 4): 5 CPU writes during sync_active -> 4 accepted, cpu_waitrequest=1 on the 5th, idle=0; after sync ends all 5 issue in order.
REQ-037 SHALL cover: rst_n pulsed with 3 writes queued -> no vram_wren after reset, idle=1, last_grant=DMA.
REQ-038 SHALL cover (FIFO off): CPU request during sync_active -> cpu_waitrequest=1 for the whole window; write issues 1 cycle after sync_active falls.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared VRAM write types: word address/data widths, write record and arbiter source id.
package vram_pkg;
    localparam int VRAM_ADDR_W = 12;
    localparam int VRAM_DATA_W = 128;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] data;
    } vram_wr_t;

    typedef enum logic {
        SRC_CPU = 1'b0,
        SRC_DMA = 1'b1
    } arb_src_t;
endpackage

// File: rtl/vram_wr_fifo.sv
// First-word-fall-through FIFO for buffered CPU writes; the head is visible combinationally
// so it can compete for the VRAM port in the same cycle.
module vram_wr_fifo import vram_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     wr_en,
    input  vram_wr_t wr_item,
    output logic     full,
    input  logic     rd_en,
    output vram_wr_t rd_item,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);

    vram_wr_t       mem [DEPTH];
    logic [AW:0]    wr_ptr_reg;
    logic [AW:0]    rd_ptr_reg;
    logic           push;
    logic           pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;
    assign rd_item = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg[AW-1:0]] <= wr_item;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end
endmodule

// File: rtl/vram_wr_arbiter.sv
// Round-robin CPU/DMA arbiter for the VRAM write port, with writes held off while the PPU syncs.
// Define VRAM_WR_ARB_FIFO_EN to buffer CPU writes in a FIFO_DEPTH-entry FIFO.
module vram_wr_arbiter import vram_pkg::*; #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [VRAM_ADDR_W-1:0] cpu_wraddr,
    input  logic [VRAM_DATA_W-1:0] cpu_wrdata,
    input  logic                   cpu_wren,
    output logic                   cpu_waitrequest,
    input  logic [VRAM_ADDR_W-1:0] dma_wraddr,
    input  logic [VRAM_DATA_W-1:0] dma_wrdata,
    input  logic                   dma_wren,
    output logic                   dma_waitrequest,
    input  logic                   sync_active,
    output logic [VRAM_ADDR_W-1:0] vram_wraddr,
    output logic [VRAM_DATA_W-1:0] vram_wrdata,
    output logic                   vram_wren,
    output logic                   idle
);
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    vram_wr_t pend_reg;
    logic     pend_valid_reg;
    arb_src_t last_grant_reg;

    vram_wr_t cpu_item;
    vram_wr_t dma_item;
    logic     cpu_cand;
    logic     cpu_q_empty;
    logic     held;
    logic     grant_ok;
    logic     grant_cpu;
    logic     grant_dma;

`ifdef VRAM_WR_ARB_FIFO_EN
    logic fifo_full;

    vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (cpu_wren),
        .wr_item ({cpu_wraddr, cpu_wrdata}),
        .full    (fifo_full),
        .rd_en   (grant_cpu),
        .rd_item (cpu_item),
        .empty   (cpu_q_empty)
    );

    assign cpu_cand        = !cpu_q_empty;
    assign cpu_waitrequest = fifo_full;
`else
    assign cpu_q_empty     = 1'b1;
    assign cpu_item        = {cpu_wraddr, cpu_wrdata};
    assign cpu_cand        = cpu_wren;
    assign cpu_waitrequest = cpu_wren && !grant_cpu;
`endif

    assign dma_item = {dma_wraddr, dma_wrdata};
    assign held     = pend_valid_reg && sync_active;
    assign grant_ok = !sync_active && !held;

    always_comb begin
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        if (grant_ok) begin
            if (cpu_cand && dma_cand_w()) begin
                grant_cpu = (last_grant_reg == SRC_DMA);
                grant_dma = (last_grant_reg == SRC_CPU);
            end else begin
                grant_cpu = cpu_cand;
                grant_dma = dma_wren;
            end
        end
    end

    function automatic logic dma_cand_w();
        return dma_wren;
    endfunction

    assign dma_waitrequest = dma_wren && !grant_dma;

    // A pending write issues as soon as sync drops, so a new grant can refill it back-to-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            last_grant_reg <= SRC_DMA;
        end else begin
            if (grant_cpu || grant_dma) begin
                pend_reg       <= grant_cpu ? cpu_item : dma_item;
                pend_valid_reg <= 1'b1;
                last_grant_reg <= grant_cpu ? SRC_CPU : SRC_DMA;
            end else if (!sync_active) begin
                pend_valid_reg <= 1'b0;
            end
        end
    end

    // The strobe is masked by sync in the same cycle so a write landing on a sync edge is held.
    assign vram_wren   = pend_valid_reg && !sync_active;
    assign vram_wraddr = pend_reg.addr;
    assign vram_wrdata = pend_reg.data;
    assign idle        = cpu_q_empty && !pend_valid_reg;
endmodule

// File: tb/tb_vram_wr_arbiter.sv
// Scoreboard bench for vram_wr_arbiter: a cycle-level reference model predicts grants and
// waitrequests, a separate monitor checks every VRAM strobe against the expected-write queue.
`timescale 1ns/1ps
module tb_vram_wr_arbiter;
    import vram_pkg::*;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [11:0]  cpu_wraddr = '0;
    logic [127:0] cpu_wrdata = '0;
    logic         cpu_wren = 1'b0;
    logic         cpu_waitrequest;
    logic [11:0]  dma_wraddr = '0;
    logic [127:0] dma_wrdata = '0;
    logic         dma_wren = 1'b0;
    logic         dma_waitrequest;
    logic         sync_active = 1'b0;
    logic [11:0]  vram_wraddr;
    logic [127:0] vram_wrdata;
    logic         vram_wren;
    logic         idle;

    always #5 clk = ~clk;

    vram_wr_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpu_wraddr      (cpu_wraddr),
        .cpu_wrdata      (cpu_wrdata),
        .cpu_wren        (cpu_wren),
        .cpu_waitrequest (cpu_waitrequest),
        .dma_wraddr      (dma_wraddr),
        .dma_wrdata      (dma_wrdata),
        .dma_wren        (dma_wren),
        .dma_waitrequest (dma_waitrequest),
        .sync_active     (sync_active),
        .vram_wraddr     (vram_wraddr),
        .vram_wrdata     (vram_wrdata),
        .vram_wren       (vram_wren),
        .idle            (idle)
    );

    int       vectors = 0;
    int       miscompares = 0;
    vram_wr_t exp_q[$];     // writes granted by the model, not yet issued
    vram_wr_t fifo_q[$];    // model of CPU writes buffered but not yet granted
    logic [11:0] issued_log[$];
    arb_src_t model_last = SRC_DMA;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive inputs, predict the grant from the arbitration rules, check waitrequests.
    task automatic drive(input logic cw, input logic [11:0] ca, input logic [127:0] cd,
                         input logic dw, input logic [11:0] da, input logic [127:0] dd,
                         input logic sy, output logic cacc, output logic dacc);
        logic g_cpu, g_dma, cand_cpu, full_pre;
        @(negedge clk);
        cpu_wren = cw; cpu_wraddr = ca; cpu_wrdata = cd;
        dma_wren = dw; dma_wraddr = da; dma_wrdata = dd;
        sync_active = sy;
        #2;
`ifdef VRAM_WR_ARB_FIFO_EN
        cand_cpu = (fifo_q.size() > 0);
`else
        cand_cpu = cw;
`endif
        full_pre = (fifo_q.size() >= DEPTH);
        g_cpu = 1'b0;
        g_dma = 1'b0;
        if (!sy) begin
            if (cand_cpu && dw) begin
                g_cpu = (model_last == SRC_DMA);
                g_dma = !g_cpu;
            end else begin
                g_cpu = cand_cpu;
                g_dma = dw;
            end
        end
        check("dma_waitrequest", dma_waitrequest, dw && !g_dma);
`ifdef VRAM_WR_ARB_FIFO_EN
        check("cpu_waitrequest", cpu_waitrequest, full_pre);
        if (g_cpu) exp_q.push_back(fifo_q.pop_front());
        cacc = cw && !full_pre;
        if (cacc) fifo_q.push_back('{addr: ca, data: cd});
`else
        check("cpu_waitrequest", cpu_waitrequest, cw && !g_cpu);
        if (g_cpu) exp_q.push_back('{addr: ca, data: cd});
        cacc = g_cpu;
`endif
        if (g_dma) exp_q.push_back('{addr: da, data: dd});
        dacc = g_dma;
        if (g_cpu) model_last = SRC_CPU;
        if (g_dma) model_last = SRC_DMA;
    endtask

    task automatic idle_cycles(input int n);
        logic a, b;
        for (int i = 0; i < n; i++) drive(1'b0, 12'h0, '0, 1'b0, 12'h0, '0, 1'b0, a, b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        cpu_wren = 1'b0; dma_wren = 1'b0; sync_active = 1'b0;
        exp_q.delete(); fifo_q.delete(); model_last = SRC_DMA;
        #1;
        check("reset vram_wren", vram_wren, 1'b0);
        check("reset vram_wraddr", vram_wraddr, 12'h0);
        check("reset vram_wrdata", vram_wrdata, 128'h0);
        check("reset idle", idle, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: samples 1 ns after the falling edge, after that cycle's inputs settle.
    initial begin
        vram_wr_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                check("vram_wren", vram_wren, (exp_q.size() > 0) && !sync_active);
                check("idle", idle, (exp_q.size() == 0) && (fifo_q.size() == 0));
                if (exp_q.size() > 0 && sync_active) begin
                    check("held vram_wraddr", vram_wraddr, exp_q[0].addr);
                    check("held vram_wrdata", vram_wrdata, exp_q[0].data);
                end
                if (vram_wren && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("vram_wraddr", vram_wraddr, e.addr);
                    check("vram_wrdata", vram_wrdata, e.data);
                    issued_log.push_back(vram_wraddr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ca_ok, da_ok, cw, dw, sy, a, b;
        logic [11:0] ca, da;
        logic [127:0] cd, dd;
        int n;

        #1;
        check("por vram_wren", vram_wren, 1'b0);
        check("por idle", idle, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Lone DMA write: accepted at once, issued one cycle later.
        issued_log.delete();
        drive(1'b0, 12'h0, '0, 1'b1, 12'h010, {16{8'hA5}}, 1'b0, a, b);
        idle_cycles(2);
        check("lone dma issued", issued_log.size(), 1);
        if (issued_log.size() > 0) check("lone dma addr", issued_log[0], 12'h010);

        // Both sources requesting continuously from reset alternate, CPU first.
        do_reset();
        issued_log.delete();
        for (int i = 0; i < 6; i++)
            drive(1'b1, 12'h001, {4{i[31:0]}}, 1'b1, 12'h002, {4{~i[31:0]}}, 1'b0, a, b);
        idle_cycles(3);
`ifndef VRAM_WR_ARB_FIFO_EN
        for (int i = 0; i < 4; i++)
            if (issued_log.size() > i) check("rr order", issued_log[i], (i % 2 == 0) ? 12'h001 : 12'h002);
        check("rr count", issued_log.size() >= 4, 1'b1);
`endif

        // DMA granted just before sync rises: held for 10 sync cycles, then issued unchanged.
        drive(1'b0, 12'h0, '0, 1'b1, 12'h0AB, {4{32'h1234_5678}}, 1'b0, a, b);
        for (int i = 0; i < 10; i++) drive(1'b0, 12'h0, '0, 1'b0, 12'h0, '0, 1'b1, a, b);
        idle_cycles(2);

`ifdef VRAM_WR_ARB_FIFO_EN
        // Five CPU writes during sync: four fit, the fifth stalls, all issue in order.
        issued_log.delete();
        n = 0;
        for (int i = 0; i < 20 && n < 5; i++) begin
            cd = {4{32'hC0DE_0000 + n}};
            drive(1'b1, 12'h100 + 12'(n), cd, 1'b0, 12'h0, '0, (i < 8), a, b);
            if (a) n++;
        end
        idle_cycles(8);
        check("fifo burst count", issued_log.size(), 5);
        for (int i = 0; i < 5; i++)
            if (issued_log.size() > i) check("fifo burst order", issued_log[i], 12'h100 + 12'(i));
`else
        // CPU request during sync stalls for the whole window, issues after sync falls.
        for (int i = 0; i < 6; i++) drive(1'b1, 12'h0C3, {4{32'hBEEF_0001}}, 1'b0, 12'h0, '0, 1'b1, a, b);
        drive(1'b1, 12'h0C3, {4{32'hBEEF_0001}}, 1'b0, 12'h0, '0, 1'b0, a, b);
        idle_cycles(2);
`endif

        // Reset with writes queued/held: nothing leaks out afterwards.
        drive(1'b0, 12'h0, '0, 1'b1, 12'h3F0, {4{32'hDEAD_0000}}, 1'b0, a, b);
        for (int i = 0; i < 3; i++) drive(1'b1, 12'h3F1 + 12'(i), {4{32'hFACE_0000}}, 1'b0, 12'h0, '0, 1'b1, a, b);
        do_reset();
        issued_log.delete();
        idle_cycles(3);
        check("no issue after reset", issued_log.size(), 0);
        drive(1'b1, 12'h111, {4{32'h1111_1111}}, 1'b1, 12'h222, {4{32'h2222_2222}}, 1'b0, a, b);
        drive(1'b1, 12'h111, {4{32'h1111_1111}}, 1'b1, 12'h222, {4{32'h2222_2222}}, 1'b0, a, b);
        idle_cycles(3);
        check("post reset first grant", issued_log.size() > 0 ? issued_log[0] : 12'hFFF,
`ifdef VRAM_WR_ARB_FIFO_EN
              12'h222);
`else
              12'h111);
`endif

        // Randomised traffic; requests are held until accepted.
        cw = 1'b0; dw = 1'b0; ca_ok = 1'b1; da_ok = 1'b1;
        ca = '0; da = '0; cd = '0; dd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!cw || ca_ok) begin
                cw = ($urandom_range(0, 2) != 0);
                ca = 12'($urandom);
                cd = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!dw || da_ok) begin
                dw = ($urandom_range(0, 2) != 0);
                da = 12'($urandom);
                dd = {$urandom, $urandom, $urandom, $urandom};
            end
            sy = ($urandom_range(0, 5) == 0);
            drive(cw, ca, cd, dw, da, dd, sy, ca_ok, da_ok);
        end
        idle_cycles(DEPTH + 4);
        check("drained", exp_q.size() + fifo_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
